mux_sel_debouncer: RTL and testbench

- Generates the registered select line `ctrl` for the downstream 2:1 mux stage from a raw, bouncy pushbutton.
- Chain: 2-flop synchronizer, then counter-based debounce FSM, then toggle register.
- Each clean press flips `ctrl` once and emits a one-cycle `press_pulse`.
- Sits between the board button pin and the mux `ctrl` input.

---
 rtl/mux_sel_debouncer_pkg.sv | 15 +
 rtl/mux_sel_debouncer_sync_2ff.sv | 24 ++
 rtl/mux_sel_debouncer.sv | 113 +++++++++++
 tb/tb_mux_sel_debouncer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_debouncer_pkg.sv
// Shared types and constants for the mux select debouncer.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // 10 ms at 100 MHz for hardware builds; the short value keeps simulations fast.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/mux_sel_debouncer_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit board input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/mux_sel_debouncer.sv
// Pushbutton to mux select: synchronize, debounce, toggle ctrl once per clean press.
module mux_sel_debouncer
  import mux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit CTRL_INIT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic clear,
  output logic ctrl,
  output logic press_pulse,
  output logic btn_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             level_q;
  logic             ctrl_q;
  logic             ctrl_d;
  logic             accept;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  assign accept = (state_q == PRESS_WAIT) && btn_sync && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_sync) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce during release returns to PRESSED without a new pulse.
          if (btn_sync) begin
            state_q <= PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  // clear wins over a coinciding toggle; the pulse still fires from the FSM.
  always_comb begin
    ctrl_d = ctrl_q;
    if (clear) begin
      ctrl_d = 1'b0;
    end else if (accept) begin
      ctrl_d = ~ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_INIT;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl        = ctrl_q;
  assign press_pulse = pulse_q;
  assign btn_level   = level_q;

endmodule

// File: tb/tb_mux_sel_debouncer.sv
// Randomized and directed checks of mux_sel_debouncer against a run-length debounce model.
module tb_mux_sel_debouncer;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic clear = 1'b0;
  logic ctrl0, pulse0, lvl0;
  logic ctrl1, pulse1, lvl1;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  int pulse_cnt0 = 0;

  always #5 clk = ~clk;

  mux_sel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM), .CTRL_INIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .clear(clear),
    .ctrl(ctrl0), .press_pulse(pulse0), .btn_level(lvl0)
  );

  mux_sel_debouncer #(.DEBOUNCE_CYCLES(1), .CTRL_INIT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .clear(clear),
    .ctrl(ctrl1), .press_pulse(pulse1), .btn_level(lvl1)
  );

  // Model: a level flips after D+1 consecutive synchronized samples that disagree with it.
  int   m_d[2] = '{DEBOUNCE_CYCLES_SIM, 1};
  logic m_dly[2];
  logic m_lvl[2];
  logic m_ctrl[2];
  logic m_pulse[2];
  int   m_run[2];
  logic samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dly[0] = 1'b0;
      m_dly[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 1'b0; m_ctrl[i] = 1'b0; m_pulse[i] = 1'b0; m_run[i] = 0;
      end
    end else begin
      samp = m_dly[1];
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0;
        if (samp != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == m_d[i] + 1) begin
            m_lvl[i] = samp;
            m_run[i] = 0;
            if (samp) begin
              m_pulse[i] = 1'b1;
              m_ctrl[i]  = ~m_ctrl[i];
            end
          end
        end else begin
          m_run[i] = 0;
        end
        if (clear) m_ctrl[i] = 1'b0;
      end
      m_dly[1] = m_dly[0];
      m_dly[0] = btn_raw;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ctrl0", ctrl0, m_ctrl[0]);
      chk("pulse0", pulse0, m_pulse[0]);
      chk("level0", lvl0, m_lvl[0]);
      chk("ctrl1", ctrl1, m_ctrl[1]);
      chk("pulse1", pulse1, m_pulse[1]);
      chk("level1", lvl1, m_lvl[1]);
      if (pulse0) pulse_cnt0++;
    end
  end

  // Leaves the bench 2 time units after a falling edge, the drive point.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  int p_before;
  int len;
  logic val;

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    $display("txn reset released");
    cyc(10);
    chk("idle_ctrl", ctrl0, 1'b0);
    chk("idle_level", lvl0, 1'b0);

    // Clean press: E0 is the next rising edge.
    btn_raw = 1'b1;
    cyc(6);
    chk("press_e5_ctrl", ctrl0, 1'b0);
    chk("press_e5_pulse", pulse0, 1'b0);
    cyc(1);
    chk("press_e6_ctrl", ctrl0, 1'b1);
    chk("press_e6_pulse", pulse0, 1'b1);
    chk("press_e6_level", lvl0, 1'b1);
    cyc(1);
    chk("press_e7_pulse", pulse0, 1'b0);
    p_before = pulse_cnt0;
    cyc(13);
    chk("hold_no_retoggle", (pulse_cnt0 == p_before), 1'b1);
    $display("txn clean press ctrl=%b", ctrl0);

    // Release with a bounce.
    btn_raw = 1'b0; cyc(2);
    btn_raw = 1'b1; cyc(1);
    btn_raw = 1'b0; cyc(12);
    chk("release_ctrl", ctrl0, 1'b1);
    chk("release_level", lvl0, 1'b0);
    chk("release_no_pulse", (pulse_cnt0 == p_before), 1'b1);
    $display("txn release bounce level=%b", lvl0);

    // Press bounce rejected by the D=4 instance.
    for (int r = 0; r < 4; r++) begin
      btn_raw = 1'b1; cyc(2);
      btn_raw = 1'b0; cyc(1);
      btn_raw = 1'b1; cyc(2);
      btn_raw = 1'b0; cyc(1);
    end
    cyc(8);
    chk("bounce_ctrl", ctrl0, 1'b1);
    chk("bounce_no_pulse", (pulse_cnt0 == p_before), 1'b1);
    $display("txn bounce reject ctrl=%b", ctrl0);

    // Clear coincides with the accepted press.
    btn_raw = 1'b1;
    cyc(6);
    clear = 1'b1;
    cyc(1);
    chk("clear_ctrl", ctrl0, 1'b0);
    chk("clear_pulse", pulse0, 1'b1);
    clear = 1'b0;
    btn_raw = 1'b0; cyc(10);
    btn_raw = 1'b1; cyc(8);
    chk("after_clear_ctrl", ctrl0, 1'b1);
    $display("txn clear priority ctrl=%b", ctrl0);

    // Reset in the middle of a press debounce (cnt=2 after E4).
    btn_raw = 1'b0; cyc(10);
    btn_raw = 1'b1;
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl0, 1'b0);
    chk("midrst_pulse", pulse0, 1'b0);
    chk("midrst_level", lvl0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("rerun_e5_level", lvl0, 1'b0);
    cyc(1);
    chk("rerun_e6_level", lvl0, 1'b1);
    chk("rerun_e6_ctrl", ctrl0, 1'b1);
    $display("txn mid-debounce reset ctrl=%b", ctrl0);

    // Randomized runs of levels, occasional clear and reset.
    for (int t = 0; t < 400; t++) begin
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      btn_raw = val;
      for (int k = 0; k < len; k++) begin
        clear = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        cyc(1);
      end
      $display("txn rand %0d btn=%b len=%0d ctrl=%b level=%b", t, val, len, ctrl0, lvl0);
    end
    rst_n = 1'b1;
    clear = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
